// File: rtl/sync_filter_edge.sv
// sync_filter_edge
//   Multi-channel input conditioner. Each raw asynchronous input passes
//   through a STAGES-deep synchronizer and then a glitch filter. The filter
//   accepts a new level only after it has been seen for FILT_CYCLES
//   consecutive clocks. Registered rise/fall pulses are produced on every
//   accepted change.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (synchronous deassertion)
//   i_d     : [WIDTH] raw asynchronous inputs
//   o_q     : [WIDTH] synchronized, filtered level
//   o_rise  : [WIDTH] one-cycle pulse on accepted 0->1
//   o_fall  : [WIDTH] one-cycle pulse on accepted 1->0
//   o_chg   : OR of all rise/fall pulses
module sync_filter_edge #(
  parameter int unsigned           WIDTH       = 4,
  parameter int unsigned           STAGES      = 2,
  parameter int unsigned           FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0]      RST_VAL     = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_chg
);

  generate
    if (WIDTH < 1 || STAGES < 2 || FILT_CYCLES < 1) begin : g_bad_params
      $error("sync_filter_edge: illegal parameters (WIDTH>=1, STAGES>=2, FILT_CYCLES>=1)");
    end
  endgenerate

  localparam int unsigned      CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] accept;

  // Synchronizer chain: plain wiring between stages.
  always_comb begin
    sync_d[0] = i_d;
    for (int unsigned k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  // Filter: a differing sample advances cnt; a matching sample clears it,
  // so any glitch back to the current level restarts the count from zero.
  always_comb begin
    level_d = level_q;
    accept  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept[i]  = 1'b1;
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = accept & s;
    fall_d = accept & ~s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_q    = level_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_chg  = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_filter_edge.sv
// Directed bench for sync_filter_edge: default instance (2 stages, filter 4)
// and a bypass instance (3 stages, filter 1). Inputs are driven 1ns after a
// rising edge; outputs are sampled at the same point, so "tick k" below
// means the k-th rising edge after the input change.
module tb_sync_filter_edge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d, d_b;
  logic [3:0] q, rise, fall;
  logic       chg;
  logic [3:0] q_b, rise_b, fall_b;
  logic       chg_b;

  int unsigned tests_run = 0;
  int unsigned fails     = 0;

  always #5 clk = ~clk;

  sync_filter_edge #(
    .WIDTH      (4),
    .STAGES     (2),
    .FILT_CYCLES(4),
    .RST_VAL    (4'h0)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (d),
    .o_q    (q),
    .o_rise (rise),
    .o_fall (fall),
    .o_chg  (chg)
  );

  sync_filter_edge #(
    .WIDTH      (4),
    .STAGES     (3),
    .FILT_CYCLES(1),
    .RST_VAL    (4'h0)
  ) u_byp (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (d_b),
    .o_q    (q_b),
    .o_rise (rise_b),
    .o_fall (fall_b),
    .o_chg  (chg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst_n = 1'b0;
    d     = 4'hF;
    d_b   = 4'h0;
    #2;
    wait_ticks(3);
    tests_run++;
    if ({q, rise, fall, chg} !== 13'h0) begin
      fails++;
      $display("FAIL reset_hold: got q=%h rise=%h fall=%h chg=%b, want all 0", q, rise, fall, chg);
    end
    tests_run++;
    if ({q_b, rise_b, fall_b, chg_b} !== 13'h0) begin
      fails++;
      $display("FAIL reset_hold_byp: got q=%h rise=%h fall=%h chg=%b, want all 0", q_b, rise_b, fall_b, chg_b);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0, k == 6};
      tests_run++;
      if ({q, rise, fall, chg} !== exp) begin
        fails++;
        $display("FAIL reset_release k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q, rise, fall, chg, exp);
      end
    end
    d = 4'h0;
    wait_ticks(8);
    tests_run++;
    if (q !== 4'h0) begin
      fails++;
      $display("FAIL reset_return_low: got q=%h, want 0", q);
    end
  endtask

  task automatic test_glitch();
    logic [12:0] exp;
    // 3-cycle pulse: rejected
    d = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) d = 4'h0;
      tests_run++;
      if ({q, rise, fall, chg} !== 13'h0) begin
        fails++;
        $display("FAIL glitch_3 k=%0d: got q=%h rise=%h fall=%h chg=%b, want all 0", k, q, rise, fall, chg);
      end
    end
    // 4-cycle pulse: accepted, then released four cycles later
    d = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) d = 4'h0;
      exp = {(k >= 6 && k < 10) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0,
             (k == 10) ? 4'h1 : 4'h0, (k == 6 || k == 10)};
      tests_run++;
      if ({q, rise, fall, chg} !== exp) begin
        fails++;
        $display("FAIL glitch_4 k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q, rise, fall, chg, exp);
      end
    end
  endtask

  task automatic test_interrupted();
    logic [12:0] exp;
    int          rises = 0;
    d = 4'h2;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) d = 4'h0;
      if (k == 4) d = 4'h2;
      if (rise[1]) rises++;
      exp = {(k >= 10) ? 4'h2 : 4'h0, (k == 10) ? 4'h2 : 4'h0, 4'h0, k == 10};
      tests_run++;
      if ({q, rise, fall, chg} !== exp) begin
        fails++;
        $display("FAIL interrupted k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q, rise, fall, chg, exp);
      end
    end
    tests_run++;
    if (rises != 1) begin
      fails++;
      $display("FAIL interrupted_count: got %0d rise pulses, want 1", rises);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    d = 4'h8;
    wait_ticks(8);
    tests_run++;
    if (q !== 4'h8) begin
      fails++;
      $display("FAIL simul_setup: got q=%h, want 8", q);
    end
    d = 4'h2;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k >= 6) ? 4'h2 : 4'h8, (k == 6) ? 4'h2 : 4'h0, (k == 6) ? 4'h8 : 4'h0, k == 6};
      tests_run++;
      if ({q, rise, fall, chg} !== exp) begin
        fails++;
        $display("FAIL simultaneous k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q, rise, fall, chg, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    d = 4'hF;
    wait_ticks(8);
    tests_run++;
    if (q !== 4'hF) begin
      fails++;
      $display("FAIL midrst_setup: got q=%h, want f", q);
    end
    // drop channel 2; after 4 edges its counter holds 2
    d = 4'hB;
    wait_ticks(4);
    rst_n = 1'b0;
    d     = 4'h4;
    #1;
    tests_run++;
    if ({q, rise, fall, chg} !== 13'h0) begin
      fails++;
      $display("FAIL midrst_async: got q=%h rise=%h fall=%h chg=%b, want all 0", q, rise, fall, chg);
    end
    wait_ticks(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {(k >= 6) ? 4'h4 : 4'h0, (k == 6) ? 4'h4 : 4'h0, 4'h0, k == 6};
      tests_run++;
      if ({q, rise, fall, chg} !== exp) begin
        fails++;
        $display("FAIL midrst_release k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q, rise, fall, chg, exp);
      end
    end
  endtask

  task automatic test_bypass();
    logic [12:0] exp;
    d_b = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) d_b = 4'h0;
      exp = {(k == 4) ? 4'h1 : 4'h0, (k == 4) ? 4'h1 : 4'h0,
             (k == 5) ? 4'h1 : 4'h0, (k == 4 || k == 5)};
      tests_run++;
      if ({q_b, rise_b, fall_b, chg_b} !== exp) begin
        fails++;
        $display("FAIL bypass k=%0d: got q=%h rise=%h fall=%h chg=%b, want %h",
                 k, q_b, rise_b, fall_b, chg_b, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_interrupted();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sync_filter_edge.md
# sync_filter_edge

Parametrised multi-channel input conditioner: each of WIDTH asynchronous inputs passes through a STAGES-deep flip-flop synchronizer and then a per-channel glitch filter. The filter accepts a new level only after it has been stable for FILT_CYCLES consecutive clocks. Per-channel registered rise and fall pulses are generated from the filtered level. It sits at the boundary between off-chip or foreign-domain signals (buttons, status lines, handshake flags) and the i_clk logic, and is the standard replacement for single-bit two-flop synchronizers.

## Interface
- WIDTH, 4: number of independent channels, ≥1.
- STAGES, 2: synchronizer flip-flops per channel, ≥2.
- FILT_CYCLES, 4: consecutive cycles a new level must persist before it is accepted. 1 means no filtering. Must be ≥1.
- RST_VAL, '0: WIDTH-bit reset value of every synchronizer stage and of o_q.
- Illegal parameter values cause an elaboration error.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset. Deassertion is synchronous to i_clk, provided by the upstream reset synchronizer.
- i_d  input  WIDTH  asynchronous raw inputs, one per channel.
- o_q  output  WIDTH  synchronized, filtered level per channel.
- o_rise  output  WIDTH  one-cycle pulse per channel on an accepted 0→1 change of o_q.
- o_fall  output  WIDTH  one-cycle pulse per channel on an accepted 1→0 change of o_q.
- o_chg  output  1  OR-reduction of (o_rise | o_fall).

## Operation
- **Synchronizer:** per channel, sync[0] <= i_d[i] and sync[k] <= sync[k-1].
  - All stages use non-blocking assignment.
  - No logic between stages.
  - The last stage is the filter input s.
- **Filter:** per channel, counter cnt of width $clog2(FILT_CYCLES), minimum 1 bit. At each edge:
  - if s == o_q[i]: cnt <= 0.
  - else if cnt == FILT_CYCLES-1: o_q[i] <= s and cnt <= 0 (accept).
  - else: cnt <= cnt+1.
- **Glitches:** any return of s to o_q[i] before acceptance clears cnt. The next differing run must start again from 0.
- **Edge pulses:** registered.
  - o_rise[i] <= accept & s.
  - o_fall[i] <= accept & ~s.
  - Pulses are high in the same cycle o_q[i] first shows the new value, and for exactly one cycle.
- **Channel independence:** channels are fully independent. Simultaneous accepts on several channels produce simultaneous pulses.
- **No FSM beyond cnt.** Per-channel state is the sync chain, cnt, o_q, o_rise and o_fall.
- **Reset (i_rst_n low):** applies immediately, without a clock edge.
  - All sync stages = RST_VAL.
  - o_q = RST_VAL.
  - cnt = 0.
  - o_rise = o_fall = 0, so o_chg = 0.
  - A reset mid-count discards the partial count.
  - No pulse is generated by reset itself.

## Timing
- **Latency:** an input change that meets setup before sampling edge e1 appears on o_q, o_rise and o_fall after edge e(STAGES+FILT_CYCLES).
  - With the defaults this is 6 edges.
- **Filter input timing:** s first reflects the change after edge e(STAGES). The filter evaluates it at edges e(STAGES+1) through e(STAGES+FILT_CYCLES).
- **Minimum accepted pulse width:** FILT_CYCLES cycles at s. Shorter runs are rejected with no output activity.
- **Toggle rate:** the maximum change rate of o_q is one change per FILT_CYCLES cycles per channel.
- **Metastability:** the first stage may go metastable. The resulting one-cycle uncertainty in latency is acceptable. Outputs are glitch-free registers, apart from o_chg, which is a single OR level.
- **First cycles after reset:** if i_d differs from RST_VAL at reset release, the first accept and pulse occur after the full latency. There is no earlier activity.

## Test plan
- **Reset/power-up:** WIDTH=4, STAGES=2, FILT=4, RST_VAL=0, i_d=4'hF held during reset.
  - During reset: o_q=0, o_rise=0, o_fall=0.
  - After release: o_q=4'hF at edge 6, o_rise=4'hF for one cycle only, o_chg=1 for that cycle.
- **Glitch rejection:**
  - i_d[0]=1 for 3 cycles → o_q[0] stays 0, no pulse.
  - i_d[0]=1 for 4 cycles → o_q[0]=1 at edge 6, o_rise[0] one cycle, o_q[0] returns to 0 four cycles later with o_fall[0].
- **Interrupted count:** i_d[1] high 3 cycles, low 1, high 4 → exactly one accept, at edge 6 of the second run, with the first run discarded.
- **Simultaneous channels:** from o_q=4'b1000, raise i_d[1] and lower i_d[3] in the same cycle → o_rise=4'b0010 and o_fall=4'b1000 in the same cycle, then o_q=4'b0010.
- **Reset mid-operation:** assert i_rst_n while channel 2 has cnt=2 and o_q=4'hF.
  - o_q=0 and pulses 0 asynchronously, before the next edge.
  - After release with i_d=4'h4, o_q=4'h4 only after a full 6 edges.
- **Bypass configuration:** STAGES=3, FILT=1.
  - A single-cycle i_d[0] pulse appears on o_q[0] after edge 4, for exactly 1 cycle.
  - o_rise[0] and o_fall[0] fire on consecutive cycles.
